// File: rtl/iter_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : iter_exec_unit
// Description : Execute unit with a single-cycle integer ALU and iterative
//               multiply/divide (RV32M semantics) behind valid/ready
//               handshakes. A pass-through tag follows every operation to
//               the result port for writeback routing.
// Ports       : CLK, RSTn            clock (rising edge), async active-low reset
//               flush                abort in-flight op, drop pending result
//               in_valid/in_ready    operation handshake
//               in_op/in_a/in_b      op code and operands
//               in_tag               tag returned with the result
//               out_valid/out_ready  result handshake
//               out_result/out_tag   result and tag of the accepted op
//               out_illegal          op code not recognised (result 0)
//               busy                 FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module iter_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int c_shw       = $clog2(XLEN);
  localparam int c_mul_steps = XLEN / MUL_BITS;
  localparam int c_cnt_w     = $clog2(XLEN);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mul  = 2'd1;
  localparam logic [1:0] c_st_div  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [4:0] c_op_add    = 5'h00;
  localparam logic [4:0] c_op_sub    = 5'h01;
  localparam logic [4:0] c_op_sll    = 5'h02;
  localparam logic [4:0] c_op_slt    = 5'h03;
  localparam logic [4:0] c_op_sltu   = 5'h04;
  localparam logic [4:0] c_op_xor    = 5'h05;
  localparam logic [4:0] c_op_srl    = 5'h06;
  localparam logic [4:0] c_op_sra    = 5'h07;
  localparam logic [4:0] c_op_or     = 5'h08;
  localparam logic [4:0] c_op_and    = 5'h09;
  localparam logic [4:0] c_op_mul    = 5'h0A;
  localparam logic [4:0] c_op_mulh   = 5'h0B;
  localparam logic [4:0] c_op_mulhsu = 5'h0C;
  localparam logic [4:0] c_op_mulhu  = 5'h0D;
  localparam logic [4:0] c_op_div    = 5'h0E;
  localparam logic [4:0] c_op_divu   = 5'h0F;
  localparam logic [4:0] c_op_rem    = 5'h10;
  localparam logic [4:0] c_op_remu   = 5'h11;

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_result;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_illegal;

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic              r_want_hi;

  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_want_rem;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic w_is_base, w_is_mul, w_is_div, w_illegal;
  logic w_accept;
  logic w_div_zero, w_div_ovf, w_div_special;
  logic [c_shw-1:0] w_shamt;

  assign w_is_base  = (in_op <= c_op_and);
  assign w_is_mul   = (in_op >= c_op_mul) && (in_op <= c_op_mulhu);
  assign w_is_div   = (in_op >= c_op_div) && (in_op <= c_op_remu);
  assign w_illegal  = !(w_is_base || w_is_mul || w_is_div);
  assign w_shamt    = in_b[c_shw-1:0];

  assign in_ready   = (r_state == c_st_idle) && (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;

  // Divide-by-zero and MIN/-1 are answered directly from IDLE.
  assign w_div_zero    = (in_b == '0);
  assign w_div_ovf     = ((in_op == c_op_div) || (in_op == c_op_rem)) &&
                         (in_a == c_int_min) && (in_b == '1);
  assign w_div_special = w_is_div && (w_div_zero || w_div_ovf);

  // --------------------------------------------------------------------------
  // Single-cycle ALU and fast-path result
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_fast_result;

  always_comb begin : p_alu
    w_alu = '0;
    case (in_op)
      c_op_add:  w_alu = in_a + in_b;
      c_op_sub:  w_alu = in_a - in_b;
      c_op_sll:  w_alu = in_a << w_shamt;
      c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      c_op_xor:  w_alu = in_a ^ in_b;
      c_op_srl:  w_alu = in_a >> w_shamt;
      c_op_sra:  w_alu = $signed(in_a) >>> w_shamt;
      c_op_or:   w_alu = in_a | in_b;
      c_op_and:  w_alu = in_a & in_b;
      default:   w_alu = '0;
    endcase
  end

  always_comb begin : p_fast
    w_fast_result = '0;
    if (w_is_base) begin
      w_fast_result = w_alu;
    end else if (w_is_div && w_div_zero) begin
      w_fast_result = ((in_op == c_op_div) || (in_op == c_op_divu)) ? '1 : in_a;
    end else if (w_is_div && w_div_ovf) begin
      // Quotient of MIN/-1 wraps back to MIN (which is in_a); remainder is 0.
      w_fast_result = (in_op == c_op_div) ? in_a : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Multiplier set-up and step
  // --------------------------------------------------------------------------
  // The multiplicand is sign-extended to the full accumulator width. The
  // multiplier bits are always retired unsigned; a negative signed multiplier
  // (value b_u - 2^XLEN) is accounted for by pre-loading the accumulator with
  // -(a << XLEN), which equals multiplying the XLEN+1-bit sign-extended
  // operands modulo 2^(2*XLEN).
  logic              w_a_sgn, w_b_sgn;
  logic [2*XLEN-1:0] w_mcand_init;
  logic [2*XLEN-1:0] w_acc_init;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN-1:0]   w_mul_result;
  logic              w_mul_last;

  assign w_a_sgn      = (in_op == c_op_mul) || (in_op == c_op_mulh) || (in_op == c_op_mulhsu);
  assign w_b_sgn      = (in_op == c_op_mul) || (in_op == c_op_mulh);
  assign w_mcand_init = w_a_sgn ? {{XLEN{in_a[XLEN-1]}}, in_a} : {{XLEN{1'b0}}, in_a};
  assign w_acc_init   = (w_b_sgn && in_b[XLEN-1]) ? -(w_mcand_init << XLEN) : '0;

  always_comb begin : p_mul_step
    w_acc_next = r_acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) begin
        w_acc_next = w_acc_next + (r_mcand << j);
      end
    end
  end

  assign w_mul_result = r_want_hi ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign w_mul_last   = (r_cnt == c_cnt_w'(c_mul_steps - 1));

  // --------------------------------------------------------------------------
  // Divider set-up and restoring step
  // --------------------------------------------------------------------------
  // Dividend bits shift out of the top of r_quo into the partial remainder
  // while quotient bits shift in at the bottom.
  logic              w_div_signed, w_sgn_a, w_sgn_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_rem_next, w_quo_next;
  logic [XLEN-1:0]   w_div_result;
  logic              w_div_last;

  assign w_div_signed = (in_op == c_op_div) || (in_op == c_op_rem);
  assign w_sgn_a      = w_div_signed && in_a[XLEN-1];
  assign w_sgn_b      = w_div_signed && in_b[XLEN-1];
  assign w_mag_a      = w_sgn_a ? -in_a : in_a;
  assign w_mag_b      = w_sgn_b ? -in_b : in_b;

  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_diff     = w_rem_sh[XLEN-1:0] - r_dvsr;
  assign w_rem_next = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

  // Sign correction is folded into the last iteration so the result is
  // registered on the same edge that completes the final step.
  assign w_div_result = r_want_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                                   : (r_neg_q ? -w_quo_next : w_quo_next);
  assign w_div_last   = (r_cnt == c_cnt_w'(XLEN - 1));

  // --------------------------------------------------------------------------
  // FSM and output registers
  // --------------------------------------------------------------------------
  // The last MUL/DIV iteration loads the output registers and moves to DONE,
  // so out_valid is seen during DONE; DONE then returns to IDLE.
  always_ff @(posedge CLK or negedge RSTn) begin : p_seq
    if (!RSTn) begin
      r_state       <= c_st_idle;
      r_cnt         <= '0;
      r_tag         <= '0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_tag     <= '0;
      r_out_illegal <= 1'b0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_want_hi     <= 1'b0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvsr        <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_want_rem    <= 1'b0;
    end else if (flush) begin
      r_state     <= c_st_idle;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_tag <= in_tag;
            r_cnt <= '0;
            if (w_is_mul) begin
              r_state   <= c_st_mul;
              r_acc     <= w_acc_init;
              r_mcand   <= w_mcand_init;
              r_mplier  <= in_b;
              r_want_hi <= (in_op != c_op_mul);
            end else if (w_is_div && !w_div_special) begin
              r_state    <= c_st_div;
              r_rem      <= '0;
              r_quo      <= w_mag_a;
              r_dvsr     <= w_mag_b;
              r_neg_q    <= w_sgn_a ^ w_sgn_b;
              r_neg_r    <= w_sgn_a;
              r_want_rem <= (in_op == c_op_rem) || (in_op == c_op_remu);
            end else begin
              r_out_valid   <= 1'b1;
              r_out_result  <= w_fast_result;
              r_out_tag     <= in_tag;
              r_out_illegal <= w_illegal;
            end
          end
        end
        c_st_mul: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_state       <= c_st_done;
            r_out_valid   <= 1'b1;
            r_out_result  <= w_mul_result;
            r_out_tag     <= r_tag;
            r_out_illegal <= 1'b0;
          end
        end
        c_st_div: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_div_last) begin
            r_state       <= c_st_done;
            r_out_valid   <= 1'b1;
            r_out_result  <= w_div_result;
            r_out_tag     <= r_tag;
            r_out_illegal <= 1'b0;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_illegal;
  assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_iter_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_exec_unit
// Description : Scoreboard bench for iter_exec_unit. Accepted operations are
//               pushed with their reference result; an independent monitor
//               compares every presented result, its latency and its
//               stability under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_exec_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_illegal;
  logic        busy;

  iter_exec_unit #(.XLEN(32), .MUL_BITS(1), .TAG_W(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rand_ready = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: RV32M rules in plain arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ovf;
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'd0; ill = 1'b0; lat = 1; p = 64'd0;
    case (op)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = a << sh;
      5'h03: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h04: r = (a < b) ? 32'd1 : 32'd0;
      5'h05: r = a ^ b;
      5'h06: r = a >> sh;
      5'h07: r = $signed(a) >>> sh;
      5'h08: r = a | b;
      5'h09: r = a & b;
      5'h0A: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0];  lat = 33; end
      5'h0B: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; lat = 33; end
      5'h0C: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; lat = 33; end
      5'h0D: begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; lat = 33; end
      5'h0E: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin r = $signed(a) / $signed(b); lat = 33; end
      end
      5'h0F: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin r = a / b; lat = 33; end
      end
      5'h10: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin r = $signed(a) % $signed(b); lat = 33; end
      end
      5'h11: begin
        if (b == 0) r = a;
        else begin r = a % b; lat = 33; end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Acceptance observer: a handshake seen at the negedge completes on the next posedge.
  always @(negedge CLK) begin : p_accept_mon
    exp_t        e;
    logic [31:0] r;
    logic        il;
    int          l;
    if (RSTn && in_valid && in_ready) begin
      model(in_op, in_a, in_b, r, il, l);
      e.res = r; e.ill = il; e.lat = l; e.tag = in_tag; e.acc_cyc = cyc;
      sb.push_back(e);
    end
  end

  // Result monitor.
  logic        p_valid = 1'b0, p_ready = 1'b0, p_flush = 1'b0, p_ill = 1'b0;
  logic [31:0] p_res = '0;
  logic [4:0]  p_tag = '0;

  always @(negedge CLK) begin : p_checker
    exp_t e;
    if (!RSTn) begin
      sb.delete();
      p_valid = 1'b0; p_ready = 1'b0; p_flush = 1'b0;
    end else begin
      if (p_valid && !p_ready && !p_flush) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, p_res);
        chk("hold_tag", out_tag, p_tag);
        chk("hold_illegal", out_illegal, p_ill);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && !(p_valid && !p_ready)) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("tag", out_tag, e.tag);
          chk("illegal", out_illegal, e.ill);
        end
      end
      if (flush) sb.delete();
      p_valid = out_valid; p_ready = out_ready; p_flush = flush;
      p_res = out_result; p_tag = out_tag; p_ill = out_illegal;
    end
  end

  always @(posedge CLK) begin : p_rand_ready
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int waited);
    waited = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge CLK);
    while (!in_ready && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    if (!in_ready) chk("issue_timeout", 1, 0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: begin v = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) v = -v; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin : p_main
    int w;
    int c0;
    logic [4:0] op;
    RSTn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 5'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(posedge CLK); #1;

    // Base op then 10 back-to-back base ops
    issue(5'h00, 32'h7FFF_FFFF, 32'd1, 5'd3, w);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      issue(5'($urandom_range(0, 9)), $urandom, $urandom, 5'(i), w);
    end
    chk("throughput_cycles", cyc - c0, 10);
    drain();

    // High-half multiplies
    issue(5'h0B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, w);
    issue(5'h0D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, w);
    issue(5'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, w);
    drain();

    // Divide: iterative and special cases
    issue(5'h0E, -32'd7, 32'd2, 5'd5, w);
    issue(5'h10, -32'd7, 32'd2, 5'd6, w);
    issue(5'h0F, 32'd5, 32'd0, 5'd7, w);
    issue(5'h10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, w);
    drain();

    // Back-pressure on a DIV result
    out_ready = 1'b0;
    issue(5'h0E, 32'd1000, -32'd9, 5'd9, w);
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(posedge CLK); #1;
    end
    repeat (5) @(posedge CLK);
    #1;
    chk("stall_valid_held", out_valid, 1);
    out_ready = 1'b1;
    drain();

    // Flush 10 cycles into a DIV with an op offered
    issue(5'h0E, 32'd123456, 32'd7, 5'd10, w);
    repeat (9) @(posedge CLK);
    #1;
    chk("div_busy", busy, 1);
    in_valid = 1'b1; in_op = 5'h00; in_a = 32'd1; in_b = 32'd2; in_tag = 5'd11;
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_in_ready", in_ready, 0);
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    issue(5'h00, 32'd1, 32'd2, 5'd11, w);
    chk("post_flush_wait", w, 0);
    drain();

    // Illegal op, then reset mid-MUL
    issue(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, w);
    issue(5'h05, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd13, w);
    drain();
    issue(5'h0A, 32'd12345, 32'd678, 5'd14, w);
    repeat (5) @(posedge CLK);
    #1;
    chk("mul_busy", busy, 1);
    RSTn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_out_tag", out_tag, 0);
    chk("midrst_out_illegal", out_illegal, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("midrst_no_result", out_valid, 0);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 21) > 17) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      issue(op, rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge CLK); #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
